// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// universal_shift_register : WIDTH-bit shift/rotate/load register with burst FSM
// Revision: 1.0
// ============================================================================
module universal_shift_register #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pdata,
  input  logic             si_left,
  input  logic             si_right,
  input  logic [CNT_W-1:0] amount,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             so_left,
  output logic             so_right,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_mode;

  logic [2:0]       w_op_mode;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_sol_nxt;
  logic             w_sor_nxt;
  logic             w_start_ok;

  // During a burst the latched mode drives the step, never the live input.
  assign w_op_mode  = (r_state == S_RUN) ? r_mode : mode;
  assign w_start_ok = (r_state == S_IDLE) && start && (mode != 3'd0) && (mode <= 3'd5);

  always_comb begin
    w_out_nxt = out;
    w_sol_nxt = so_left;
    w_sor_nxt = so_right;
    case (w_op_mode)
      3'd1: begin
        w_out_nxt = {si_left, out[WIDTH-1:1]};
        w_sor_nxt = out[0];
      end
      3'd2: begin
        w_out_nxt = {out[WIDTH-2:0], si_right};
        w_sol_nxt = out[WIDTH-1];
      end
      3'd3: begin
        w_out_nxt = {out[0], out[WIDTH-1:1]};
        w_sor_nxt = out[0];
      end
      3'd4: begin
        w_out_nxt = {out[WIDTH-2:0], out[WIDTH-1]};
        w_sol_nxt = out[WIDTH-1];
      end
      3'd5: begin
        w_out_nxt = {out[WIDTH-1], out[WIDTH-1:1]};
        w_sor_nxt = out[0];
      end
      3'd6:    w_out_nxt = pdata;
      3'd7:    w_out_nxt = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      so_left  <= 1'b0;
      so_right <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_mode   <= 3'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            // A zero-length burst completes immediately without touching the data.
            if (amount != '0) begin
              r_mode  <= mode;
              r_count <= amount;
              r_state <= S_RUN;
              busy    <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            out      <= w_out_nxt;
            so_left  <= w_sol_nxt;
            so_right <= w_sor_nxt;
          end
        end
        S_RUN: begin
          out      <= w_out_nxt;
          so_left  <= w_sol_nxt;
          so_right <= w_sor_nxt;
          r_count  <= r_count - 1'b1;
          if (r_count == CNT_W'(1)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// tb_universal_shift_register : directed + randomized checks against a queue model
// Revision: 1.0
// ============================================================================
module tb_universal_shift_register;

  localparam int W = 4;
  localparam int C = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [W-1:0] pdata = '0;
  logic         si_left = 1'b0;
  logic         si_right = 1'b0;
  logic [C-1:0] amount = '0;
  logic         start = 1'b0;
  logic [W-1:0] out;
  logic         so_left, so_right, busy, done;

  int checks = 0;
  int errors = 0;

  // Reference state: a burst is a queue of pending single-step operations.
  int m_out, m_sol, m_sor, m_busy, m_done;
  int q[$];

  universal_shift_register #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .pdata(pdata),
    .si_left(si_left), .si_right(si_right), .amount(amount), .start(start),
    .out(out), .so_left(so_left), .so_right(so_right), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_sol = 0; m_sor = 0; m_busy = 0; m_done = 0;
    q.delete();
  endtask

  task automatic model_apply(input int op);
    int b;
    case (op)
      1: begin m_sor = m_out & 1; m_out = (m_out >> 1) | (int'(si_left) << (W-1)); end
      2: begin m_sol = (m_out >> (W-1)) & 1; m_out = ((m_out << 1) & MASK) | int'(si_right); end
      3: begin b = m_out & 1; m_sor = b; m_out = (m_out >> 1) | (b << (W-1)); end
      4: begin b = (m_out >> (W-1)) & 1; m_sol = b; m_out = ((m_out << 1) & MASK) | b; end
      5: begin m_sor = m_out & 1; m_out = (m_out >> 1) | (m_out & (1 << (W-1))); end
      6: m_out = int'(pdata);
      7: m_out = 0;
      default: ;
    endcase
  endtask

  task automatic model_edge();
    m_done = 0;
    if (q.size() > 0) begin
      model_apply(q.pop_front());
      if (q.size() == 0) m_done = 1;
    end else if (start && mode >= 1 && mode <= 5) begin
      if (amount == 0) m_done = 1;
      else for (int i = 0; i < int'(amount); i++) q.push_back(int'(mode));
    end else if (en) begin
      model_apply(int'(mode));
    end
    m_busy = (q.size() != 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("out", 32'(out), 32'(m_out));
    check("so_left", 32'(so_left), 32'(m_sol));
    check("so_right", 32'(so_right), 32'(m_sor));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
  endtask

  // Inputs are applied at negedge; one posedge; compare at the following negedge.
  task automatic cyc(input logic e, input logic [2:0] md, input logic [W-1:0] pd,
                     input logic sl, input logic sr, input logic [C-1:0] amt, input logic st);
    en = e; mode = md; pdata = pd; si_left = sl; si_right = sr; amount = amt; start = st;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out", 32'(out), 32'd0);
    check("rst_so", 32'({so_left, so_right}), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Reset drops asynchronously while out is all ones.
    cyc(1, 3'd6, 4'b1111, 0, 0, 0, 0);
    check("pre_rst", 32'(out), 32'hF);
    mid_reset();

    // Shift right with si_left=1.
    cyc(1, 3'd6, 4'b1011, 0, 0, 0, 0);
    cyc(1, 3'd1, 4'b0000, 1, 0, 0, 0);
    check("shr1", 32'({out, so_right}), 32'b11011);
    cyc(1, 3'd1, 4'b0000, 1, 0, 0, 0);
    check("shr2", 32'({out, so_right}), 32'b11101);

    // Arithmetic right then clear.
    cyc(1, 3'd6, 4'b1001, 0, 0, 0, 0);
    cyc(1, 3'd5, 4'b0000, 0, 0, 0, 0);
    check("asr1", 32'(out), 32'b1100);
    cyc(1, 3'd5, 4'b0000, 0, 0, 0, 0);
    check("asr2", 32'(out), 32'b1110);
    cyc(1, 3'd7, 4'b0000, 0, 0, 0, 0);
    check("clr", 32'(out), 32'b0000);

    // Rotate left four times returns to the start pattern.
    cyc(1, 3'd6, 4'b1001, 0, 0, 0, 0);
    cyc(1, 3'd4, 4'b0000, 0, 0, 0, 0); check("rol1", 32'({out, so_left}), 32'b00111);
    cyc(1, 3'd4, 4'b0000, 0, 0, 0, 0); check("rol2", 32'({out, so_left}), 32'b01100);
    cyc(1, 3'd4, 4'b0000, 0, 0, 0, 0); check("rol3", 32'({out, so_left}), 32'b11000);
    cyc(1, 3'd4, 4'b0000, 0, 0, 0, 0); check("rol4", 32'({out, so_left}), 32'b10011);

    // Burst left by 3 while en/mode/start are toggled.
    cyc(1, 3'd6, 4'b0001, 0, 0, 0, 0);
    cyc(0, 3'd2, 4'b0000, 0, 0, 4'd3, 1);
    check("burst_go", 32'({out, busy, done}), 32'b000110);
    cyc(1, 3'd7, 4'b1111, 0, 0, 4'd2, 1); check("burst1", 32'({out, busy, done}), 32'b001010);
    cyc(0, 3'd6, 4'b1111, 0, 0, 4'd0, 0); check("burst2", 32'({out, busy, done}), 32'b010010);
    cyc(1, 3'd3, 4'b1111, 0, 0, 4'd1, 1); check("burst3", 32'({out, busy, done}), 32'b100001);
    cyc(0, 3'd0, 4'b0000, 0, 0, 4'd0, 0); check("burst_after", 32'({busy, done}), 32'b00);

    // Abort a burst with reset, then a zero-length start.
    cyc(1, 3'd6, 4'b1010, 0, 0, 0, 0);
    cyc(0, 3'd1, 4'b0000, 1, 0, 4'd5, 1);
    cyc(0, 3'd0, 4'b0000, 1, 0, 4'd0, 0);
    cyc(0, 3'd0, 4'b0000, 1, 0, 4'd0, 0);
    check("abort_pre", 32'({out, busy}), 32'b11101);
    mid_reset();
    cyc(0, 3'd0, 4'b0000, 0, 0, 4'd0, 0);
    check("abort_nodone", 32'({out, busy, done}), 32'b000000);
    cyc(1, 3'd6, 4'b0110, 0, 0, 0, 0);
    cyc(0, 3'd1, 4'b0000, 1, 0, 4'd0, 1);
    check("zero_amt", 32'({out, busy, done}), 32'b011001);
    cyc(0, 3'd0, 4'b0000, 0, 0, 4'd0, 0);
    check("zero_amt_after", 32'({busy, done}), 32'b00);

    // Randomized traffic against the queue model, with occasional async resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
      end else begin
        cyc(1'($urandom), 3'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            C'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
